// File: rtl/ysyx_24080014_ifu_if.sv
// Fetch-unit bus bundle: next-PC input, memory request/response channel and decode output.
// The IFU drives the master side; memory, jump logic and decode sit on the slave side.
interface ysyx_24080014_ifu_if;
   logic        npc_valid;
   logic [31:0] npc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  inst_fault;
   logic [31:0] fetch_cnt;

   modport master (
      input  npc_valid, npc, req_ready, resp_valid, resp_data, resp_err, inst_ready,
      output req_valid, req_addr, resp_ready, inst_valid, inst, inst_pc, inst_fault, fetch_cnt
   );

   modport slave (
      output npc_valid, npc, req_ready, resp_valid, resp_data, resp_err, inst_ready,
      input  req_valid, req_addr, resp_ready, inst_valid, inst, inst_pc, inst_fault, fetch_cnt
   );
endinterface

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time and hands
// each instruction with its PC and fault code to decode.
module ysyx_24080014_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   ysyx_24080014_ifu_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_OUT,
      S_WAIT
   } state_t;

   localparam logic [31:0] INST_NOP   = 32'h0000_0013;
   localparam logic [1:0]  FAULT_NONE = 2'b00;
   localparam logic [1:0]  FAULT_MIS  = 2'b10;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [1:0]  r_fault;
   logic [31:0] r_fetch_cnt;
   logic        r_req_valid;
   logic        r_resp_ready;
   logic        r_inst_valid;

   logic        w_npc_aligned;

   assign w_npc_aligned = (bus.npc[1:0] == 2'b00);

   // Handshake outputs are registered alongside the state so no input reaches an output combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_inst       <= '0;
         r_fault      <= FAULT_NONE;
         r_fetch_cnt  <= '0;
         r_req_valid  <= 1'b0;
         r_resp_ready <= 1'b0;
         r_inst_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state     <= S_REQ;
               r_req_valid <= 1'b1;
            end
            S_REQ: begin
               if (bus.req_ready) begin
                  r_state      <= S_RESP;
                  r_req_valid  <= 1'b0;
                  r_resp_ready <= 1'b1;
               end
            end
            S_RESP: begin
               if (bus.resp_valid) begin
                  r_state      <= S_OUT;
                  r_inst       <= bus.resp_data;
                  r_fault      <= {1'b0, bus.resp_err};
                  r_resp_ready <= 1'b0;
                  r_inst_valid <= 1'b1;
               end
            end
            S_OUT: begin
               if (bus.inst_ready) begin
                  r_state      <= S_WAIT;
                  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
                  r_inst_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.npc_valid) begin
                  r_pc <= bus.npc;
                  if (w_npc_aligned) begin
                     r_state     <= S_REQ;
                     r_req_valid <= 1'b1;
                  end else begin
                     // Misaligned target: skip memory and deliver a NOP tagged with the fault.
                     r_state      <= S_OUT;
                     r_inst       <= INST_NOP;
                     r_fault      <= FAULT_MIS;
                     r_inst_valid <= 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_valid  <= 1'b0;
               r_resp_ready <= 1'b0;
               r_inst_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_valid  = r_req_valid;
   assign bus.req_addr   = r_pc;
   assign bus.resp_ready = r_resp_ready;
   assign bus.inst_valid = r_inst_valid;
   assign bus.inst       = r_inst;
   assign bus.inst_pc    = r_pc;
   assign bus.inst_fault = r_fault;
   assign bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Bench for ysyx_24080014_ifu: directed sequences, a vector table of fetch transactions,
// and a randomized run scored against a transaction-level model of the fetch loop.
module tb_ysyx_24080014_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n;

   ysyx_24080014_ifu_if bus ();

   ysyx_24080014_ifu #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] npc;
      logic [31:0] data;
      logic        err;
      logic        fetch;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic [1:0]  e_fault;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [1:0]  fault;
   } item_t;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [31:0] exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.npc_valid  = 1'b0;
      bus.npc        = '0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      bus.resp_err   = 1'b0;
      bus.inst_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_valid"},  bus.req_valid,  1'b0);
      check({tag, " resp_ready"}, bus.resp_ready, 1'b0);
      check({tag, " inst_valid"}, bus.inst_valid, 1'b0);
      check({tag, " inst"},       bus.inst,       32'h0);
      check({tag, " inst_fault"}, bus.inst_fault, 2'b00);
      check({tag, " fetch_cnt"},  bus.fetch_cnt,  32'h0);
      check({tag, " inst_pc"},    bus.inst_pc,    RST_PC);
      check({tag, " req_addr"},   bus.req_addr,   RST_PC);
   endtask

   // Zero-wait transaction starting at a negedge with the IFU in WAIT.
   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      bus.npc_valid = 1'b1;
      bus.npc       = v.npc;
      @(negedge clk);
      bus.npc_valid = 1'b0;
      if (v.fetch) begin
         check({tag, " req_valid"}, bus.req_valid, 1'b1);
         check({tag, " req_addr"},  bus.req_addr,  v.e_pc);
         bus.req_ready = 1'b1;
         @(negedge clk);
         bus.req_ready = 1'b0;
         check({tag, " resp_ready"}, bus.resp_ready, 1'b1);
         bus.resp_valid = 1'b1;
         bus.resp_data  = v.data;
         bus.resp_err   = v.err;
         @(negedge clk);
         bus.resp_valid = 1'b0;
      end else begin
         check({tag, " no req"}, bus.req_valid, 1'b0);
      end
      check({tag, " inst_valid"}, bus.inst_valid, 1'b1);
      check({tag, " inst"},       bus.inst,       v.e_inst);
      check({tag, " inst_pc"},    bus.inst_pc,    v.e_pc);
      check({tag, " inst_fault"}, bus.inst_fault, v.e_fault);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      exp_cnt++;
      check({tag, " inst_valid drop"}, bus.inst_valid, 1'b0);
      check({tag, " fetch_cnt"},       bus.fetch_cnt,  exp_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [8];
      item_t       q [$];
      item_t       it;
      logic [31:0] m_pc, m_data, v;
      logic        m_exp_req, m_pend, m_err, m_wait;
      logic        resp_fire, npc_fire;
      int unsigned m_dly, m_ndly;
      logic [31:0] m_cnt;

      vt[0] = '{32'h8000_0010, 32'h0000_0093, 1'b0, 1'b1, 32'h0000_0093, 32'h8000_0010, 2'b00};
      vt[1] = '{32'h8000_0006, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0013, 32'h8000_0006, 2'b10};
      vt[2] = '{32'h8000_0020, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h8000_0020, 2'b01};
      vt[3] = '{32'h8000_0101, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0013, 32'h8000_0101, 2'b10};
      vt[4] = '{32'h8000_0103, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0013, 32'h8000_0103, 2'b10};
      vt[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
      vt[6] = '{32'hFFFF_FFFC, 32'h0000_A0B3, 1'b1, 1'b1, 32'h0000_A0B3, 32'hFFFF_FFFC, 2'b01};
      vt[7] = '{32'h8000_0002, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0013, 32'h8000_0002, 2'b10};

      idle_inputs();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // First fetch after reset; npc_valid pulses outside WAIT must not move the PC.
      @(negedge clk);
      check("s1 req_valid", bus.req_valid, 1'b1);
      check("s1 req_addr",  bus.req_addr,  RST_PC);
      bus.npc_valid = 1'b1;
      bus.npc       = 32'h1234_5670;
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      check("s1 resp_ready", bus.resp_ready, 1'b1);
      check("s1 req_valid drop", bus.req_valid, 1'b0);
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'h0000_0093;
      bus.resp_err   = 1'b0;
      @(negedge clk);
      bus.resp_valid = 1'b0;
      check("s1 inst_valid", bus.inst_valid, 1'b1);
      check("s1 inst",       bus.inst,       32'h0000_0093);
      check("s1 inst_pc",    bus.inst_pc,    RST_PC);
      check("s1 inst_fault", bus.inst_fault, 2'b00);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      bus.npc_valid  = 1'b0;
      exp_cnt = 32'd1;
      check("s1 fetch_cnt", bus.fetch_cnt, exp_cnt);
      check("s1 pc kept",   bus.req_addr,  RST_PC);
      check("s1 wait idle", bus.req_valid, 1'b0);

      for (int i = 0; i < 8; i++) run_vec(vt[i], i);

      // Back-pressure on every channel; outputs must hold and only one request is issued.
      bus.npc_valid = 1'b1;
      bus.npc       = 32'h8000_0040;
      @(negedge clk);
      bus.npc_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp req_valid hold", bus.req_valid, 1'b1);
         check("bp req_addr hold",  bus.req_addr,  32'h8000_0040);
         @(negedge clk);
      end
      check("bp req_valid", bus.req_valid, 1'b1);
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("bp resp_ready hold", bus.resp_ready, 1'b1);
         check("bp single req",      bus.req_valid,  1'b0);
         check("bp no inst",         bus.inst_valid, 1'b0);
         @(negedge clk);
      end
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'h00A0_0513;
      bus.resp_err   = 1'b0;
      @(negedge clk);
      bus.resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp inst_valid hold", bus.inst_valid, 1'b1);
         check("bp inst hold",       bus.inst,       32'h00A0_0513);
         check("bp inst_pc hold",    bus.inst_pc,    32'h8000_0040);
         check("bp fault hold",      bus.inst_fault, 2'b00);
         check("bp single req",      bus.req_valid,  1'b0);
         if (i == 2) bus.inst_ready = 1'b1;
         @(negedge clk);
      end
      bus.inst_ready = 1'b0;
      exp_cnt++;
      check("bp fetch_cnt", bus.fetch_cnt, exp_cnt);
      check("bp inst drop", bus.inst_valid, 1'b0);

      // Asynchronous reset while a response is pending, then counter wrap.
      bus.npc_valid = 1'b1;
      bus.npc       = 32'h8000_0080;
      @(negedge clk);
      bus.npc_valid = 1'b0;
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      check("rst resp_ready", bus.resp_ready, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 32'd0;
      @(negedge clk);
      check("wrap req_valid", bus.req_valid, 1'b1);
      check("wrap req_addr",  bus.req_addr,  RST_PC);
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'h0000_0513;
      @(negedge clk);
      bus.resp_valid = 1'b0;
      check("wrap inst", bus.inst, 32'h0000_0513);
      force dut.r_fetch_cnt = 32'hFFFF_FFFF;
      #1 release dut.r_fetch_cnt;
      #1 check("wrap preload", bus.fetch_cnt, 32'hFFFF_FFFF);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      check("wrap fetch_cnt", bus.fetch_cnt, 32'h0);
      check("wrap inst drop", bus.inst_valid, 1'b0);

      // Randomized run: the model tracks which transaction is open and what decode must see next.
      m_pc      = RST_PC;
      m_cnt     = 32'h0;
      m_exp_req = 1'b0;
      m_pend    = 1'b0;
      m_wait    = 1'b1;
      m_ndly    = 0;
      m_dly     = 0;
      m_data    = '0;
      m_err     = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         check("rnd req_valid",  bus.req_valid,  m_exp_req);
         check("rnd resp_ready", bus.resp_ready, m_pend);
         check("rnd inst_valid", bus.inst_valid, q.size() != 0);
         check("rnd fetch_cnt",  bus.fetch_cnt,  m_cnt);
         if (bus.req_valid) check("rnd req_addr", bus.req_addr, m_pc);
         if (bus.inst_valid && q.size() != 0) begin
            check("rnd inst",       bus.inst,       q[0].inst);
            check("rnd inst_pc",    bus.inst_pc,    q[0].pc);
            check("rnd inst_fault", bus.inst_fault, q[0].fault);
         end

         bus.req_ready  = ($urandom % 3) != 0;
         bus.inst_ready = ($urandom % 3) != 0;
         resp_fire = m_pend && (m_dly == 0);
         if (resp_fire) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = m_data;
            bus.resp_err   = m_err;
         end else begin
            bus.resp_valid = m_pend ? 1'b0 : (($urandom % 4) == 0);
            bus.resp_data  = $urandom;
            bus.resp_err   = $urandom % 2;
            if (m_pend) m_dly--;
         end
         npc_fire = m_wait && (m_ndly == 0);
         if (npc_fire) begin
            v = $urandom;
            if (($urandom % 4) != 0) v[1:0] = 2'b00;
            bus.npc_valid = 1'b1;
            bus.npc       = v;
         end else begin
            bus.npc_valid = m_wait ? 1'b0 : (($urandom % 4) == 0);
            bus.npc       = $urandom;
            if (m_wait) m_ndly--;
         end

         if (q.size() != 0 && bus.inst_ready) begin
            void'(q.pop_front());
            m_cnt++;
            m_wait = 1'b1;
            m_ndly = $urandom % 3;
         end
         if (resp_fire) begin
            it = '{m_data, m_pc, {1'b0, m_err}};
            q.push_back(it);
            m_pend = 1'b0;
         end
         if (m_exp_req && bus.req_ready) begin
            m_exp_req = 1'b0;
            m_pend    = 1'b1;
            m_dly     = $urandom % 4;
            m_data    = $urandom;
            m_err     = ($urandom % 8) == 0;
         end
         if (npc_fire) begin
            m_wait = 1'b0;
            m_pc   = bus.npc;
            if (bus.npc[1:0] == 2'b00) m_exp_req = 1'b1;
            else begin
               it = '{32'h0000_0013, bus.npc, 2'b10};
               q.push_back(it);
            end
         end
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
